// File: rtl/sensors_scan_avg.sv
// Sequential sensor scanner: sums, counts and tracks min/max over enabled
// channels LANES at a time, then derives the floor average with a
// one-bit-per-cycle restoring divider. Results update together on valid_o.
module sensors_scan_avg #(
    parameter int NR_SENSORS = 200,
    parameter int DATA_W     = 8,
    parameter int LANES      = 4,
    parameter int SUM_W      = 16,
    parameter int CNT_W      = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         start_i,
    input  logic [DATA_W*NR_SENSORS-1:0] sensors_data_i,
    input  logic [NR_SENSORS-1:0]        sensors_en_i,
    output logic                         busy_o,
    output logic                         valid_o,
    output logic [SUM_W-1:0]             temp_sum_o,
    output logic [CNT_W-1:0]             nr_active_sensors_o,
    output logic [DATA_W-1:0]            temp_avg_o,
    output logic [DATA_W-1:0]            temp_min_o,
    output logic [DATA_W-1:0]            temp_max_o
);

    localparam int NB    = (NR_SENSORS + LANES - 1) / LANES;
    localparam int PAD_N = NB * LANES;
    localparam int BLK_W = (NB > 1) ? $clog2(NB) : 1;
    localparam int DIV_W = $clog2(SUM_W + 1);

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DIVIDE, S_DONE} state_t;

    state_t              r_state;
    logic [BLK_W-1:0]    r_blk;
    logic [SUM_W-1:0]    r_sum;
    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_W-1:0]   r_min;
    logic [DATA_W-1:0]   r_max;
    logic [SUM_W-1:0]    r_quo;
    logic [SUM_W-1:0]    r_rem;
    logic [DIV_W-1:0]    r_div_cnt;
    logic                r_busy;
    logic                r_valid;
    logic [SUM_W-1:0]    r_o_sum;
    logic [CNT_W-1:0]    r_o_cnt;
    logic [DATA_W-1:0]   r_o_avg;
    logic [DATA_W-1:0]   r_o_min;
    logic [DATA_W-1:0]   r_o_max;

    logic [DATA_W*PAD_N-1:0] w_data_pad;
    logic [PAD_N-1:0]        w_en_pad;
    logic [DATA_W-1:0]       w_lane;
    logic [SUM_W-1:0]        w_sum_nx;
    logic [CNT_W-1:0]        w_cnt_nx;
    logic [DATA_W-1:0]       w_min_nx;
    logic [DATA_W-1:0]       w_max_nx;
    logic [SUM_W:0]          w_rem_sh;
    logic [SUM_W:0]          w_div;
    logic                    w_ge;
    logic [SUM_W-1:0]        w_quo_nx;

    // Zero-pad the channel bus to whole blocks so phantom lanes read as disabled
    always_comb begin
        w_data_pad = '0;
        w_en_pad   = '0;
        w_data_pad[DATA_W*NR_SENSORS-1:0] = sensors_data_i;
        w_en_pad[NR_SENSORS-1:0]          = sensors_en_i;
    end

    // Fold every enabled lane of the current block into the running totals
    always_comb begin
        w_sum_nx = r_sum;
        w_cnt_nx = r_cnt;
        w_min_nx = r_min;
        w_max_nx = r_max;
        w_lane   = '0;
        for (int l = 0; l < LANES; l++) begin
            w_lane = w_data_pad[(int'(r_blk) * LANES + l) * DATA_W +: DATA_W];
            if (w_en_pad[int'(r_blk) * LANES + l]) begin
                w_sum_nx = w_sum_nx + SUM_W'(w_lane);
                w_cnt_nx = w_cnt_nx + CNT_W'(1);
                if (w_lane < w_min_nx) w_min_nx = w_lane;
                if (w_lane > w_max_nx) w_max_nx = w_lane;
            end
        end
    end

    // One restoring-division step: r_quo shifts dividend bits out the top and
    // quotient bits in at the bottom
    always_comb begin
        w_rem_sh = {r_rem, r_quo[SUM_W-1]};
        w_div    = (SUM_W+1)'(r_cnt);
        w_ge     = (w_rem_sh >= w_div);
        w_quo_nx = {r_quo[SUM_W-2:0], w_ge};
    end

    // Scan/divide FSM with registered status and result outputs
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= S_IDLE;
            r_blk     <= '0;
            r_sum     <= '0;
            r_cnt     <= '0;
            r_min     <= '0;
            r_max     <= '0;
            r_quo     <= '0;
            r_rem     <= '0;
            r_div_cnt <= '0;
            r_busy    <= 1'b0;
            r_valid   <= 1'b0;
            r_o_sum   <= '0;
            r_o_cnt   <= '0;
            r_o_avg   <= '0;
            r_o_min   <= '0;
            r_o_max   <= '0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_state <= S_ACCUM;
                        r_blk   <= '0;
                        r_sum   <= '0;
                        r_cnt   <= '0;
                        r_min   <= '1;
                        r_max   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                S_ACCUM: begin
                    r_sum <= w_sum_nx;
                    r_cnt <= w_cnt_nx;
                    r_min <= w_min_nx;
                    r_max <= w_max_nx;
                    r_blk <= r_blk + BLK_W'(1);
                    if (r_blk == BLK_W'(NB - 1)) begin
                        if (w_cnt_nx != '0) begin
                            r_state   <= S_DIVIDE;
                            r_quo     <= w_sum_nx;
                            r_rem     <= '0;
                            r_div_cnt <= '0;
                        end else begin
                            // nothing enabled: skip the divider, report all zeros
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_valid <= 1'b1;
                            r_o_sum <= '0;
                            r_o_cnt <= '0;
                            r_o_avg <= '0;
                            r_o_min <= '0;
                            r_o_max <= '0;
                        end
                    end
                end
                S_DIVIDE: begin
                    r_quo     <= w_quo_nx;
                    r_rem     <= w_ge ? SUM_W'(w_rem_sh - w_div) : w_rem_sh[SUM_W-1:0];
                    r_div_cnt <= r_div_cnt + DIV_W'(1);
                    if (r_div_cnt == DIV_W'(SUM_W - 1)) begin
                        // average fits DATA_W, so truncating the quotient is exact
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_valid <= 1'b1;
                        r_o_sum <= r_sum;
                        r_o_cnt <= r_cnt;
                        r_o_avg <= w_quo_nx[DATA_W-1:0];
                        r_o_min <= r_min;
                        r_o_max <= r_max;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy_o              = r_busy;
    assign valid_o             = r_valid;
    assign temp_sum_o          = r_o_sum;
    assign nr_active_sensors_o = r_o_cnt;
    assign temp_avg_o          = r_o_avg;
    assign temp_min_o          = r_o_min;
    assign temp_max_o          = r_o_max;

endmodule

// File: tb/tb_sensors_scan_avg.sv
// Self-checking bench: random and directed scans compared against a plain
// arithmetic reference (loop over channels, integer divide).
module tb_sensors_scan_avg;

    localparam int NR = 200;
    localparam int DW = 8;
    localparam int LN = 4;
    localparam int SW = 16;
    localparam int CW = 8;
    localparam int NB = (NR + LN - 1) / LN;
    localparam int RW = SW + CW + 3*DW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [DW*NR-1:0] data = '0;
    logic [NR-1:0]    en = '0;
    logic          busy, valid;
    logic [SW-1:0] t_sum;
    logic [CW-1:0] t_cnt;
    logic [DW-1:0] t_avg, t_min, t_max;

    logic          start6 = 1'b0;
    logic [DW*6-1:0] data6 = '0;
    logic [5:0]    en6 = '0;
    logic          busy6, valid6;
    logic [SW-1:0] t_sum6;
    logic [CW-1:0] t_cnt6;
    logic [DW-1:0] t_avg6, t_min6, t_max6;

    int errors = 0;
    int checks = 0;

    sensors_scan_avg u_dut (
        .clk_i(clk), .rst_i(rst), .start_i(start),
        .sensors_data_i(data), .sensors_en_i(en),
        .busy_o(busy), .valid_o(valid), .temp_sum_o(t_sum),
        .nr_active_sensors_o(t_cnt), .temp_avg_o(t_avg),
        .temp_min_o(t_min), .temp_max_o(t_max)
    );

    sensors_scan_avg #(.NR_SENSORS(6), .DATA_W(8), .LANES(4), .SUM_W(16), .CNT_W(8)) u_dut6 (
        .clk_i(clk), .rst_i(rst), .start_i(start6),
        .sensors_data_i(data6), .sensors_en_i(en6),
        .busy_o(busy6), .valid_o(valid6), .temp_sum_o(t_sum6),
        .nr_active_sensors_o(t_cnt6), .temp_avg_o(t_avg6),
        .temp_min_o(t_min6), .temp_max_o(t_max6)
    );

    always #5 clk = ~clk;

    // Reference: {sum, count, avg, min, max} of the enabled channels
    function automatic logic [RW-1:0] model(input logic [DW*NR-1:0] d, input logic [NR-1:0] e, input int n);
        int s, c, mn, mx, v;
        s = 0; c = 0; mn = 1 << DW; mx = -1;
        for (int i = 0; i < n; i++) begin
            if (e[i]) begin
                v = int'(d[DW*i +: DW]);
                s += v; c++;
                if (v < mn) mn = v;
                if (v > mx) mx = v;
            end
        end
        if (c == 0) return '0;
        return {SW'(s), CW'(c), DW'(s / c), DW'(mn), DW'(mx)};
    endfunction

    function automatic int exp_lat(input logic [RW-1:0] r);
        logic [CW-1:0] c;
        c = r[3*DW +: CW];
        return (c != 0) ? NB + SW : NB;
    endfunction

    // Drive one start pulse on the main DUT and watch it until valid_o + 3 cycles
    task automatic run_scan(input int restart_at, input bit start_in_done,
                            output int lat, output int busy_cyc, output int pulses);
        @(negedge clk) start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        lat = -1; pulses = 0;
        busy_cyc = busy ? 1 : 0;
        for (int i = 1; i <= 150; i++) begin
            @(posedge clk); #1;
            if (valid) begin
                if (lat < 0) lat = i;
                pulses++;
            end
            if (busy) busy_cyc++;
            start = (i == restart_at) || (start_in_done && valid);
            if (lat >= 0 && i >= lat + 3) break;
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        #12;
        checks++;
        if ({busy, valid, t_sum, t_cnt, t_avg, t_min, t_max} !== '0) begin
            errors++;
            $display("FAIL reset_state: got busy=%b valid=%b sum=%0d cnt=%0d avg=%0d min=%0d max=%0d expected all 0",
                     busy, valid, t_sum, t_cnt, t_avg, t_min, t_max);
        end
        @(negedge clk) rst = 1'b0;
    endtask

    task automatic check_scan(input string name, input int lat, input int bc, input int p, input int elat);
        logic [RW-1:0] exp_r, got_r;
        exp_r = model(data, en, NR);
        got_r = {t_sum, t_cnt, t_avg, t_min, t_max};
        checks++;
        if (lat !== elat) begin
            errors++;
            $display("FAIL %s latency: got %0d expected %0d", name, lat, elat);
        end
        checks++;
        if (bc !== elat) begin
            errors++;
            $display("FAIL %s busy_cycles: got %0d expected %0d", name, bc, elat);
        end
        checks++;
        if (p !== 1) begin
            errors++;
            $display("FAIL %s valid_pulses: got %0d expected 1", name, p);
        end
        checks++;
        if (got_r !== exp_r) begin
            errors++;
            $display("FAIL %s results: got sum=%0d cnt=%0d avg=%0d min=%0d max=%0d expected sum=%0d cnt=%0d avg=%0d min=%0d max=%0d",
                     name, t_sum, t_cnt, t_avg, t_min, t_max,
                     exp_r[RW-1 -: SW], exp_r[3*DW +: CW], exp_r[2*DW +: DW], exp_r[DW +: DW], exp_r[0 +: DW]);
        end
    endtask

    task automatic test_all_25;
        int lat, bc, p;
        for (int i = 0; i < NR; i++) data[DW*i +: DW] = 8'd25;
        en = '1;
        run_scan(-1, 1'b0, lat, bc, p);
        check_scan("all25", lat, bc, p, 66);
        checks++;
        if ({t_sum, t_avg} !== {16'd5000, 8'd25}) begin
            errors++;
            $display("FAIL all25 abs: got sum=%0d avg=%0d expected 5000 25", t_sum, t_avg);
        end
    endtask

    task automatic test_none_enabled;
        int lat, bc, p;
        for (int i = 0; i < NR; i++) data[DW*i +: DW] = DW'($urandom);
        en = '0;
        run_scan(-1, 1'b0, lat, bc, p);
        check_scan("none_en", lat, bc, p, 50);
    endtask

    task automatic test_sparse;
        int lat, bc, p;
        data = '0; en = '0;
        data[0 +: DW] = 8'd10;   en[0] = 1'b1;
        data[DW*5 +: DW] = 8'd3;
        data[DW*199 +: DW] = 8'd255; en[199] = 1'b1;
        run_scan(-1, 1'b0, lat, bc, p);
        check_scan("sparse", lat, bc, p, 66);
        checks++;
        if ({t_sum, t_cnt, t_avg, t_min, t_max} !== {16'd265, 8'd2, 8'd132, 8'd10, 8'd255}) begin
            errors++;
            $display("FAIL sparse abs: got sum=%0d cnt=%0d avg=%0d min=%0d max=%0d expected 265 2 132 10 255",
                     t_sum, t_cnt, t_avg, t_min, t_max);
        end
    endtask

    task automatic test_random;
        int lat, bc, p, dens;
        for (int t = 0; t < 10; t++) begin
            dens = (t == 0) ? 1 : int'($urandom_range(0, 100));
            for (int i = 0; i < NR; i++) begin
                data[DW*i +: DW] = DW'($urandom);
                en[i] = (int'($urandom_range(0, 99)) < dens);
            end
            run_scan(-1, 1'b0, lat, bc, p);
            check_scan($sformatf("random%0d", t), lat, bc, p, exp_lat(model(data, en, NR)));
        end
    endtask

    task automatic test_ignored_starts;
        int lat, bc, p;
        for (int i = 0; i < NR; i++) begin
            data[DW*i +: DW] = DW'($urandom);
            en[i] = 1'($urandom);
        end
        run_scan(10, 1'b1, lat, bc, p);
        check_scan("ignored_starts", lat, bc, p, exp_lat(model(data, en, NR)));
    endtask

    task automatic test_reset_mid_divide;
        int lat, bc, p, seen;
        for (int i = 0; i < NR; i++) data[DW*i +: DW] = DW'($urandom_range(1, 255));
        en = '1;
        @(negedge clk) start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (55) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        checks++;
        if ({busy, valid, t_sum, t_cnt, t_avg, t_min, t_max} !== '0) begin
            errors++;
            $display("FAIL reset_mid_divide: got busy=%b valid=%b sum=%0d cnt=%0d avg=%0d min=%0d max=%0d expected all 0",
                     busy, valid, t_sum, t_cnt, t_avg, t_min, t_max);
        end
        @(negedge clk) rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk); #1;
            if (valid || busy) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL reset_abort: got %0d busy/valid cycles expected 0", seen);
        end
        run_scan(-1, 1'b0, lat, bc, p);
        check_scan("after_reset", lat, bc, p, 66);
    endtask

    task automatic test_small;
        logic [DW*NR-1:0] d;
        logic [NR-1:0] e;
        logic [RW-1:0] exp_r;
        int lat, pulses;
        for (int t = 0; t < 3; t++) begin
            for (int i = 0; i < 6; i++) begin
                data6[DW*i +: DW] = (t == 0) ? DW'(i + 1) : DW'($urandom);
                en6[i] = (t == 0) ? 1'b1 : 1'($urandom);
            end
            d = '0; e = '0;
            d[DW*6-1:0] = data6; e[5:0] = en6;
            exp_r = model(d, e, 6);
            @(negedge clk) start6 = 1'b1;
            @(posedge clk); #1 start6 = 1'b0;
            lat = -1; pulses = 0;
            for (int i = 1; i <= 60; i++) begin
                @(posedge clk); #1;
                if (valid6) begin
                    if (lat < 0) lat = i;
                    pulses++;
                end
                if (lat >= 0 && i >= lat + 3) break;
            end
            checks++;
            if (lat !== ((exp_r[3*DW +: CW] != 0) ? 2 + SW : 2)) begin
                errors++;
                $display("FAIL small%0d latency: got %0d expected %0d", t, lat,
                         (exp_r[3*DW +: CW] != 0) ? 2 + SW : 2);
            end
            checks++;
            if (pulses !== 1) begin
                errors++;
                $display("FAIL small%0d valid_pulses: got %0d expected 1", t, pulses);
            end
            checks++;
            if ({t_sum6, t_cnt6, t_avg6, t_min6, t_max6} !== exp_r) begin
                errors++;
                $display("FAIL small%0d results: got sum=%0d cnt=%0d avg=%0d min=%0d max=%0d expected %h",
                         t, t_sum6, t_cnt6, t_avg6, t_min6, t_max6, exp_r);
            end
            if (t == 0) begin
                checks++;
                if ({t_sum6, t_cnt6, t_avg6, t_min6, t_max6} !== {16'd21, 8'd6, 8'd3, 8'd1, 8'd6}) begin
                    errors++;
                    $display("FAIL small_abs: got sum=%0d cnt=%0d avg=%0d min=%0d max=%0d expected 21 6 3 1 6",
                             t_sum6, t_cnt6, t_avg6, t_min6, t_max6);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_all_25();
        test_none_enabled();
        test_sparse();
        test_random();
        test_ignored_starts();
        test_reset_mid_divide();
        test_small();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
